// File: rtl/adc_spi_pkg.sv
// Shared types and constants for the ADC/PLL configuration SPI master.
package adc_spi_pkg;

  localparam int SPI_FRAME_W = 16;
  localparam int SPI_RW_BIT  = 15;
  localparam logic SPI_RW_READ = 1'b1;
  localparam int SPI_TURN_BIT = 7;
  localparam int SPI_DIV_W  = 16;
  localparam int SPI_H_W    = SPI_DIV_W + 1;
  localparam int SPI_HALF_W = $clog2(2 * SPI_FRAME_W);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP,
    ST_ACK
  } spi_state_e;

  // Index of the SCLK half-period whose closing tick is the falling edge that starts bit b.
  function automatic logic [SPI_HALF_W-1:0] half_before_bit(input int unsigned b);
    return SPI_HALF_W'(2 * (SPI_FRAME_W - 1 - b) - 1);
  endfunction

endpackage

// File: rtl/adc_spi_clkgen.sv
// Half-period tick generator: one-cycle tick every H enabled cycles, restarted on clr_i.
module adc_spi_clkgen
  import adc_spi_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clr_i,
  input  logic               en_i,
  input  logic [SPI_H_W-1:0] h_i,
  output logic               tick_o
);

  localparam logic [SPI_H_W-1:0] H_ONE = SPI_H_W'(1);

  logic [SPI_H_W-1:0] cnt_q, cnt_d;
  logic               at_end;

  // 17-bit compare so H = 65536 counts the full range before ticking.
  assign at_end = (cnt_q == (h_i - H_ONE));
  assign tick_o = en_i & ~clr_i & at_end;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = at_end ? '0 : cnt_q + H_ONE;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/adc_spi3w_master.sv
// Single-register read/write SPI master for the ADC/PLL configuration port (3-wire bus).
// Define ADC_SPI_4WIRE_EN to hold spi_dir at 1 and treat spi_in as a dedicated MISO.
module adc_spi3w_master
  import adc_spi_pkg::*;
#(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [SPI_DIV_W-1:0] clk_div_cnt,
  input  logic                 cmd_read,
  input  logic                 cmd_write,
  input  logic [ADDR_W-1:0]    read_addr,
  input  logic [ADDR_W-1:0]    write_addr,
  input  logic [DATA_W-1:0]    write_data,
  output logic                 cmd_read_ack,
  output logic                 cmd_write_ack,
  output logic [DATA_W-1:0]    read_data,
  output logic                 spi_ce,
  output logic                 spi_sclk,
  output logic                 spi_dir,
  output logic                 spi_out,
  input  logic                 spi_in
);

`ifdef ADC_SPI_4WIRE_EN
  localparam logic TURNAROUND_EN = 1'b0;
`else
  localparam logic TURNAROUND_EN = 1'b1;
`endif

  localparam logic [SPI_HALF_W-1:0] HALF_LAST = SPI_HALF_W'(2 * SPI_FRAME_W - 1);
  localparam logic [SPI_HALF_W-1:0] HALF_TURN = half_before_bit(SPI_TURN_BIT);
  localparam logic [SPI_HALF_W-1:0] HALF_ONE  = SPI_HALF_W'(1);
  localparam logic [SPI_H_W-1:0]    H_ONE     = SPI_H_W'(1);

  spi_state_e               state_q, state_d;
  logic [SPI_H_W-1:0]       h_q, h_d;
  logic                     is_read_q, is_read_d;
  logic [SPI_FRAME_W-1:0]   tx_q, tx_d;
  logic [DATA_W-1:0]        rx_q, rx_d;
  logic [DATA_W-1:0]        rdata_q, rdata_d;
  logic [SPI_HALF_W-1:0]    half_q, half_d;
  logic                     ce_q, ce_d;
  logic                     sclk_q, sclk_d;
  logic                     dir_q, dir_d;
  logic                     rd_ack_q, rd_ack_d;
  logic                     wr_ack_q, wr_ack_d;
  logic                     accept;
  logic                     cnt_en;
  logic                     tick;

  assign cnt_en = (state_q != ST_IDLE) && (state_q != ST_ACK);

  adc_spi_clkgen u_clkgen (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (accept),
    .en_i   (cnt_en),
    .h_i    (h_q),
    .tick_o (tick)
  );

  always_comb begin
    state_d   = state_q;
    h_d       = h_q;
    is_read_d = is_read_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    rdata_d   = rdata_q;
    half_d    = half_q;
    ce_d      = ce_q;
    sclk_d    = sclk_q;
    dir_d     = dir_q;
    rd_ack_d  = 1'b0;
    wr_ack_d  = 1'b0;
    accept    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_write || cmd_read) begin
          // A simultaneous read stays pending behind the write.
          accept    = 1'b1;
          is_read_d = ~cmd_write;
          h_d       = {1'b0, clk_div_cnt} + H_ONE;
          tx_d      = cmd_write ? {~SPI_RW_READ, write_addr, write_data}
                                : {SPI_RW_READ, read_addr, {DATA_W{1'b0}}};
          half_d    = '0;
          ce_d      = 1'b0;
          sclk_d    = 1'b0;
          dir_d     = 1'b1;
          state_d   = ST_SETUP;
        end
      end

      ST_SETUP: begin
        if (tick) state_d = ST_SHIFT;
      end

      ST_SHIFT: begin
        if (tick) begin
          if (!half_q[0]) begin
            sclk_d = 1'b1;
            rx_d   = {rx_q[DATA_W-2:0], spi_in};
            half_d = half_q + HALF_ONE;
          end else begin
            sclk_d = 1'b0;
            tx_d   = tx_q << 1;
            if (half_q == HALF_LAST) begin
              dir_d   = 1'b1;
              state_d = ST_HOLD;
            end else begin
              half_d = half_q + HALF_ONE;
              // Hand the data pin to the slave for the data byte of a read.
              if (TURNAROUND_EN && is_read_q && (half_q == HALF_TURN)) dir_d = 1'b0;
            end
          end
        end
      end

      ST_HOLD: begin
        if (tick) begin
          ce_d    = 1'b1;
          state_d = ST_GAP;
        end
      end

      ST_GAP: begin
        if (tick) begin
          state_d = ST_ACK;
          if (is_read_q) begin
            rd_ack_d = 1'b1;
            rdata_d  = rx_q;
          end else begin
            wr_ack_d = 1'b1;
          end
        end
      end

      ST_ACK: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      h_q       <= H_ONE;
      is_read_q <= 1'b0;
      tx_q      <= '0;
      rx_q      <= '0;
      rdata_q   <= '0;
      half_q    <= '0;
      ce_q      <= 1'b1;
      sclk_q    <= 1'b0;
      dir_q     <= 1'b1;
      rd_ack_q  <= 1'b0;
      wr_ack_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      h_q       <= h_d;
      is_read_q <= is_read_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      rdata_q   <= rdata_d;
      half_q    <= half_d;
      ce_q      <= ce_d;
      sclk_q    <= sclk_d;
      dir_q     <= dir_d;
      rd_ack_q  <= rd_ack_d;
      wr_ack_q  <= wr_ack_d;
    end
  end

  assign spi_out       = tx_q[SPI_RW_BIT];
  assign spi_ce        = ce_q;
  assign spi_sclk      = sclk_q;
  assign spi_dir       = dir_q;
  assign cmd_read_ack  = rd_ack_q;
  assign cmd_write_ack = wr_ack_q;
  assign read_data     = rdata_q;

endmodule

// File: tb/tb_adc_spi3w_master.sv
// Self-checking bench for adc_spi3w_master: expected waveforms derived from frame timing arithmetic.
module tb_adc_spi3w_master;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] clk_div_cnt;
  logic        cmd_read, cmd_write;
  logic [6:0]  read_addr, write_addr;
  logic [7:0]  write_data;
  logic        cmd_read_ack, cmd_write_ack;
  logic [7:0]  read_data;
  logic        spi_ce, spi_sclk, spi_dir, spi_out, spi_in;

`ifdef ADC_SPI_4WIRE_EN
  localparam bit TB_TURN = 1'b0;
`else
  localparam bit TB_TURN = 1'b1;
`endif

  int         checks = 0;
  int         errors = 0;
  int         ce_run = 0;
  int         last_ce_run = 0;
  logic [7:0] model_rdata = 8'h00;

  bit         wr;
  logic [6:0] wa, ra;
  logic [7:0] wd, sl;
  int         h;
  int         ack_seen;

  always #5 clk = ~clk;

  adc_spi3w_master #(.ADDR_W(7), .DATA_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .clk_div_cnt   (clk_div_cnt),
    .cmd_read      (cmd_read),
    .cmd_write     (cmd_write),
    .read_addr     (read_addr),
    .write_addr    (write_addr),
    .write_data    (write_data),
    .cmd_read_ack  (cmd_read_ack),
    .cmd_write_ack (cmd_write_ack),
    .read_data     (read_data),
    .spi_ce        (spi_ce),
    .spi_sclk      (spi_sclk),
    .spi_dir       (spi_dir),
    .spi_out       (spi_out),
    .spi_in        (spi_in)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic track_ce();
    if (spi_ce === 1'b1) begin
      ce_run++;
    end else begin
      if (ce_run > 0) last_ce_run = ce_run;
      ce_run = 0;
    end
  endtask

  // Called at a negedge; the following posedge is the accept edge.
  task automatic start_cmd(input bit w, input bit r, input logic [6:0] waddr,
                           input logic [7:0] wdata, input logic [6:0] raddr,
                           input logic [15:0] div);
    write_addr  = waddr;
    write_data  = wdata;
    read_addr   = raddr;
    clk_div_cnt = div;
    cmd_write   = w;
    cmd_read    = r;
  endtask

  // Cycle k = period after the k-th posedge counting the accept edge as 0.
  task automatic watch_frame(input string tag, input bit rd, input logic [15:0] frame,
                             input logic [7:0] slave, input int hh, input bit scramble);
    logic [15:0] got, slave_word;
    int   rises, bad_ce, bad_sclk, bad_dir, bad_out, early_ack, last;
    logic prev_sclk, prev_out, exp_ce, exp_sclk, exp_dir;
    got = '0; rises = 0; bad_ce = 0; bad_sclk = 0; bad_dir = 0; bad_out = 0; early_ack = 0;
    prev_sclk = 1'b0; prev_out = 1'b0;
    last = 35 * hh + 1;
    slave_word = {8'h00, slave};
    spi_in = slave_word[15];
    for (int cyc = 1; cyc <= last; cyc++) begin
      @(negedge clk);
      track_ce();
      if (scramble && cyc == 3) begin
        write_addr  = 7'($urandom);
        write_data  = 8'($urandom);
        read_addr   = 7'($urandom);
        clk_div_cnt = 16'($urandom_range(0, 7));
      end
      exp_ce   = !(cyc <= 34 * hh);
      exp_sclk = (cyc > hh) && (cyc <= 33 * hh) && (((cyc - 1) / hh) % 2 == 0);
      exp_dir  = !(TB_TURN && rd && (cyc >= 17 * hh + 1) && (cyc <= 33 * hh));
      if (spi_ce !== exp_ce) bad_ce++;
      if (spi_sclk !== exp_sclk) bad_sclk++;
      if (spi_dir !== exp_dir) bad_dir++;
      if (spi_sclk === 1'b1 && spi_out !== prev_out) bad_out++;
      if (spi_sclk === 1'b1 && prev_sclk === 1'b0) begin
        got = {got[14:0], spi_out};
        rises++;
        if (rises < 16) spi_in = slave_word[15-rises];
      end
      if (cyc < last && (cmd_read_ack | cmd_write_ack) !== 1'b0) early_ack++;
      prev_sclk = spi_sclk;
      prev_out  = spi_out;
    end
    check({tag, "_frame"}, got, frame);
    check({tag, "_rises"}, rises, 16);
    check({tag, "_ce"}, bad_ce, 0);
    check({tag, "_sclk"}, bad_sclk, 0);
    check({tag, "_dir"}, bad_dir, 0);
    check({tag, "_out_hold"}, bad_out, 0);
    check({tag, "_early_ack"}, early_ack, 0);
    check({tag, "_ack"}, rd ? cmd_read_ack : cmd_write_ack, 1);
    check({tag, "_other_ack"}, rd ? cmd_write_ack : cmd_read_ack, 0);
    if (rd) model_rdata = slave;
    check({tag, "_rdata"}, read_data, model_rdata);
    if (rd) cmd_read = 1'b0;
    else    cmd_write = 1'b0;
    @(negedge clk);
    track_ce();
    check({tag, "_ack_pulse"}, {cmd_read_ack, cmd_write_ack}, 2'b00);
    spi_in = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    cmd_read = 1'b0; cmd_write = 1'b0;
    read_addr = '0; write_addr = '0; write_data = '0;
    clk_div_cnt = '0; spi_in = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ce", spi_ce, 1);
    check("rst_sclk", spi_sclk, 0);
    check("rst_dir", spi_dir, 1);
    check("rst_out", spi_out, 0);
    check("rst_acks", {cmd_read_ack, cmd_write_ack}, 2'b00);
    check("rst_rdata", read_data, 8'h00);
    rst = 1'b0;
    @(negedge clk);

    // Abort a read (H=2) in the high half of bit 10: cycles 25..26.
    start_cmd(1'b0, 1'b1, 7'h00, 8'h00, 7'($urandom), 16'd1);
    for (int c = 1; c <= 25; c++) @(negedge clk);
    check("abort_pre_sclk", spi_sclk, 1);
    check("abort_pre_ce", spi_ce, 0);
    #2 rst = 1'b1;
    #1;
    check("abort_ce", spi_ce, 1);
    check("abort_sclk", spi_sclk, 0);
    check("abort_dir", spi_dir, 1);
    check("abort_out", spi_out, 0);
    check("abort_acks", {cmd_read_ack, cmd_write_ack}, 2'b00);
    cmd_read = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    ack_seen = 0;
    repeat (80) begin
      @(negedge clk);
      if ((cmd_read_ack | cmd_write_ack) === 1'b1) ack_seen++;
    end
    check("abort_no_ack", ack_seen, 0);
    check("abort_rdata", read_data, model_rdata);

    // Write 0x18 / 0x00, H=1.
    start_cmd(1'b1, 1'b0, 7'h18, 8'h00, 7'h00, 16'd0);
    watch_frame("wr18", 1'b0, 16'h1800, 8'h00, 1, 1'b1);

    // Read 0x19, slave returns 0x07, H=4.
    start_cmd(1'b0, 1'b1, 7'h00, 8'h00, 7'h19, 16'd3);
    watch_frame("rd19", 1'b1, 16'h9900, 8'h07, 4, 1'b1);

    // Simultaneous requests: write first, read follows after an H+2 deselect.
    wa = 7'($urandom); wd = 8'($urandom); ra = 7'($urandom); sl = 8'($urandom);
    h  = $urandom_range(1, 3);
    start_cmd(1'b1, 1'b1, wa, wd, ra, 16'(h - 1));
    watch_frame("both_wr", 1'b0, {1'b0, wa, wd}, 8'h00, h, 1'b0);
    watch_frame("both_rd", 1'b1, {1'b1, ra, 8'h00}, sl, h, 1'b1);
    check("both_gap", last_ce_run, h + 2);

    for (int i = 0; i < 4; i++) begin
      wr = 1'($urandom_range(0, 1));
      wa = 7'($urandom); wd = 8'($urandom); sl = 8'($urandom);
      h  = $urandom_range(1, 4);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      if (wr) begin
        start_cmd(1'b1, 1'b0, wa, wd, 7'h00, 16'(h - 1));
        watch_frame("rnd_wr", 1'b0, {1'b0, wa, wd}, 8'h00, h, 1'b1);
      end else begin
        start_cmd(1'b0, 1'b1, 7'h00, 8'h00, wa, 16'(h - 1));
        watch_frame("rnd_rd", 1'b1, {1'b1, wa, 8'h00}, sl, h, 1'b1);
      end
    end

    // Read 0x18 returning 0xA5 (dir expectation follows the build).
    start_cmd(1'b0, 1'b1, 7'h00, 8'h00, 7'h18, 16'd1);
    watch_frame("rd18", 1'b1, 16'h9800, 8'hA5, 2, 1'b1);
    repeat (3) @(negedge clk);
    check("rd18_hold", read_data, 8'hA5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_spi3w_master.md
# adc_spi3w_master

SPI master engine that executes single-register read and write transactions on the ADC/PLL configuration port. It sits directly below the configuration sequencer, which issues level requests and waits for a one-cycle acknowledge. It drives the shared 3-wire bus (`spi_ce`, `spi_sclk`, `spi_out`/`spi_in` with direction control `spi_dir`). Each transaction is one 16-bit frame: R/W flag, 7-bit register address, 8-bit data.

## Interface
- `ADDR_W`, 7, register address width
- `DATA_W`, 8, register data width
- `clk  in  1  system clock`
- `rst  in  1  asynchronous, active-high reset`
- `clk_div_cnt  in  16  SCLK half-period minus one, in clk cycles (H = clk_div_cnt+1); sampled at accept`
- `cmd_read  in  1  read request, level, held until ack`
- `cmd_write  in  1  write request, level, held until ack`
- `read_addr  in  ADDR_W  register address for reads`
- `write_addr  in  ADDR_W  register address for writes`
- `write_data  in  DATA_W  write payload`
- `cmd_read_ack  out  1  one-cycle pulse: read complete, read_data valid`
- `cmd_write_ack  out  1  one-cycle pulse: write complete`
- `read_data  out  DATA_W  last read result, held until next read completes`
- `spi_ce  out  1  chip enable, active low`
- `spi_sclk  out  1  serial clock, idle low (CPOL=0)`
- `spi_dir  out  1  1 = master drives data pin, 0 = slave drives`
- `spi_out  out  1  serial data to slave`
- `spi_in  in  1  serial data from slave`

## Operation
- Reset values: spi_ce=1, spi_sclk=0, spi_dir=1, spi_out=0, both acks 0, read_data=0, state IDLE.
- Frame (MSB first): bit15 = R/W (1 = read), bits14:8 = address, bits7:0 = data (writes: write_data; reads: don't-care, drive 0).
- States: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> ACK -> IDLE.
- IDLE: on a clk edge with cmd_write or cmd_read high, latch the addr/data/type, latch H, load the shift register, go to SETUP. If both are high, the write wins; the read stays pending.
- SETUP (H cycles): spi_ce=0, sclk=0, spi_out = bit15.
- SHIFT (16 bits, each H cycles low then H cycles high):
  - spi_out changes only while sclk is low, at the start of each low half.
  - The edge that raises sclk also captures spi_in into the receive shift register.
- Read turnaround: spi_dir=1 through bit8 (last address bit). spi_dir=0 from the falling edge that starts bit7 until HOLD entry. Writes keep spi_dir=1 throughout.
- HOLD (H cycles): spi_ce=0, sclk=0, spi_dir=1.
- GAP (H cycles): spi_ce=1, giving the minimum deselect time.
- ACK (1 cycle): pulse the matching ack. For reads, read_data updates on the edge entering ACK.
- Request changes after accept are ignored.
- If cmd is still high in the cycle after ACK, a new transaction is accepted; requesters deassert on the ack cycle.
- Reset mid-transaction: all outputs return to reset values immediately (async). No ack is issued for the aborted frame.

## Timing
- Accept edge = cycle 0. spi_ce falls in cycle 1.
- Ack high exactly in cycle 35·H+1. With H=1 that is cycle 36; with clk_div_cnt=3 (H=4) it is cycle 141.
- SCLK period = 2H clk cycles, duty 50%, exactly 16 rising edges per frame.
- clk_div_cnt=0xFFFF gives H=65536. The half-period counter is 17 bits and must not wrap early.
- Back-to-back transactions: minimum spi_ce high time is H+2 cycles (GAP + ACK + IDLE accept).

## Configuration
- `ADC_SPI_4WIRE_EN`:
  - Defined: spi_dir is constant 1 and spi_in is treated as a dedicated MISO. Sampling is unchanged.
  - Undefined (default): 3-wire turnaround as described in Operation.

## Structure
- Package `adc_spi_pkg` holds:
  - state enum
  - `SPI_FRAME_W=16`
  - `SPI_RW_BIT=15`
  - `SPI_RW_READ=1'b1`
  - turnaround bit index (7)
- Sub-module `adc_spi_clkgen`: given H and an enable, produces one-cycle half-period tick pulses; reset by rst and on accept.

## Test plan
- Write addr 0x18 data 0x00, H=1: spi_out stream 0x1800 MSB-first, spi_dir=1 throughout, cmd_write_ack in cycle 36, cmd_read_ack stays 0.
- Read addr 0x19, slave returns 0x07, H=4:
  - command bits 0x99 shifted out
  - spi_dir falls at the start of bit7
  - read_data=0x07 at cmd_read_ack in cycle 141
- cmd_read and cmd_write asserted together: write frame first. After the write ack, the read is accepted with a spi_ce high gap of H+2 cycles.
- rst asserted during bit 10 of a read: spi_ce=1, sclk=0, spi_dir=1 immediately; no ack; read_data keeps its prior value. The next request completes normally.
- clk_div_cnt changed mid-frame: frame timing uses the H latched at accept.
- Build with ADC_SPI_4WIRE_EN, read addr 0x18 returning 0xA5: spi_dir stays 1, read_data=0xA5.
